rs_decode_wrapper: RTL

//  Receive-side companion of the RS encode core: sits under a TL-UL reg top (rs_decode_reg_top).

---
 rtl/rs_decode_pkg.sv | 62 ++++++
 rtl/rs_decode_wrapper_cell.sv | 29 ++
 rtl/rs_decode_wrapper.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rs_decode_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the RS(200,168) syndrome decoder.
// The alpha-power table is built at elaboration time from the field polynomial.
package rs_decode_pkg;

  localparam int GF_W    = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int NSYM    = 32;
  localparam int N_WORDS = 50;
  localparam int K_WORDS = 42;
  localparam int FCR     = 0;

  localparam int N_BYTES = N_WORDS * 4;
  localparam int CW_W    = N_WORDS * 32;
  localparam int DATA_W  = K_WORDS * 32;
  localparam int SYN_W   = NSYM * GF_W;
  localparam logic [7:0] ACC_LAST = 8'(N_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [NSYM-1:0][GF_W-1:0] alpha_tbl_t;

  // Shift-and-add multiply; with one constant operand this reduces to a pure XOR network.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < GF_W; k++) begin
      if (b[k]) begin
        acc = acc ^ sh;
      end
      if (sh[GF_W-1]) begin
        sh = {sh[GF_W-2:0], 1'b0} ^ GF_POLY[GF_W-1:0];
      end else begin
        sh = {sh[GF_W-2:0], 1'b0};
      end
    end
    return acc;
  endfunction

  function automatic alpha_tbl_t gen_alpha_pow();
    alpha_tbl_t      tbl;
    logic [GF_W-1:0] p;
    p = 8'h01;
    for (int e = 0; e < FCR; e++) begin
      p = gf_mul(p, 8'h02);
    end
    for (int i = 0; i < NSYM; i++) begin
      tbl[i] = p;
      p      = gf_mul(p, 8'h02);
    end
    return tbl;
  endfunction

  localparam alpha_tbl_t ALPHA_POW = gen_alpha_pow();

endpackage

// File: rtl/rs_decode_wrapper_cell.sv
// One syndrome accumulator: Horner step S <= S*ROOT ^ r per received symbol.
// Cleared at the start of every decode and by the soft clear.
module rs_syndrome_cell
  import rs_decode_pkg::*;
#(
  parameter logic [GF_W-1:0] ROOT = 8'h01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [GF_W-1:0] sym,
  output logic [GF_W-1:0] syn
);

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn <= 8'h00;
    end else if (clr) begin
      syn <= 8'h00;
    end else if (en) begin
      syn <= gf_mul(syn, ROOT) ^ sym;
    end else begin
      syn <= syn;
    end
  end

endmodule

// File: rtl/rs_decode_wrapper.sv
// RS(200,168) receive-side syndrome engine: loads a codeword, streams it byte-serially
// through NSYM parallel syndrome cells and publishes results as hw2reg d/de pairs.
module rs_decode_wrapper
  import rs_decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clrn,
  input  logic                 decode_en,
  input  logic [CW_W-1:0]      codeword_in,
  output logic [DATA_W-1:0]    data_out,
  output logic [SYN_W-1:0]     syndrome_out,
  output logic                 err_detect,
  output logic                 valid,
  output logic                 ready,
  output logic                 valid_re,
  output logic                 ready_re,
  output logic                 err_re,
  output logic [K_WORDS-1:0]   data_re,
  output logic [NSYM/4-1:0]    syndrome_re
);

  state_e                      state_r;
  state_e                      state_nxt_s;
  logic                        decode_en_q_r;
  logic                        start_s;
  logic [7:0]                  cnt_r;
  logic [CW_W-1:0]             shreg_r;
  logic [NSYM-1:0][GF_W-1:0]   syn_s;
  logic                        syn_clr_s;
  logic                        syn_en_s;
  logic [GF_W-1:0]             sym_s;

  assign start_s   = decode_en & ~decode_en_q_r;
  assign syn_clr_s = (state_r == ST_LOAD) | ~clrn;
  assign syn_en_s  = (state_r == ST_ACCUM);
  assign sym_s     = shreg_r[CW_W-1 -: GF_W];

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nxt_s = ST_ACCUM;
      ST_ACCUM: begin
        if (cnt_r == ACC_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; soft clear forces IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Start edge detector; tracks decode_en even during clear so no start fires on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_en_q_r <= 1'b0;
    end else begin
      decode_en_q_r <= decode_en;
    end
  end

  // Symbol stream: the register rotates rather than shifts, so after all 200 symbols it
  // again holds the captured codeword and the data words can be published from it in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {CW_W{1'b0}};
      cnt_r   <= 8'd0;
    end else if (!clrn) begin
      shreg_r <= {CW_W{1'b0}};
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          shreg_r <= codeword_in;
          cnt_r   <= 8'd0;
        end
        ST_ACCUM: begin
          shreg_r <= {shreg_r[CW_W-GF_W-1:0], shreg_r[CW_W-1 -: GF_W]};
          cnt_r   <= cnt_r + 8'd1;
        end
        default: begin
          shreg_r <= shreg_r;
          cnt_r   <= cnt_r;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NSYM; i++) begin : g_syn
    rs_syndrome_cell #(
      .ROOT (ALPHA_POW[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (syn_clr_s),
      .en    (syn_en_s),
      .sym   (sym_s),
      .syn   (syn_s[i])
    );
  end

  // hw2reg outputs and their de strobes; a strobe is high only in the cycle its value updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= {DATA_W{1'b0}};
      syndrome_out <= {SYN_W{1'b0}};
      err_detect   <= 1'b0;
      valid        <= 1'b0;
      ready        <= 1'b1;
      valid_re     <= 1'b0;
      ready_re     <= 1'b0;
      err_re       <= 1'b0;
      data_re      <= {K_WORDS{1'b0}};
      syndrome_re  <= {(NSYM/4){1'b0}};
    end else if (!clrn) begin
      data_out     <= {DATA_W{1'b0}};
      syndrome_out <= {SYN_W{1'b0}};
      err_detect   <= 1'b0;
      valid        <= 1'b0;
      ready        <= 1'b1;
      valid_re     <= 1'b1;
      ready_re     <= 1'b1;
      err_re       <= 1'b1;
      data_re      <= {K_WORDS{1'b1}};
      syndrome_re  <= {(NSYM/4){1'b1}};
    end else begin
      valid_re    <= 1'b0;
      ready_re    <= 1'b0;
      err_re      <= 1'b0;
      data_re     <= {K_WORDS{1'b0}};
      syndrome_re <= {(NSYM/4){1'b0}};
      case (state_r)
        ST_LOAD: begin
          ready    <= 1'b0;
          ready_re <= 1'b1;
          valid    <= 1'b0;
          valid_re <= valid;
        end
        ST_DONE: begin
          data_out     <= shreg_r[CW_W-1 -: DATA_W];
          syndrome_out <= syn_s;
          err_detect   <= |syn_s;
          valid        <= 1'b1;
          ready        <= 1'b1;
          valid_re     <= 1'b1;
          ready_re     <= 1'b1;
          err_re       <= 1'b1;
          data_re      <= {K_WORDS{1'b1}};
          syndrome_re  <= {(NSYM/4){1'b1}};
        end
        default: begin
          valid <= valid;
          ready <= ready;
        end
      endcase
    end
  end

endmodule
